// File: rtl/uart_rx_if.sv
// Receive-side bundle of uart_rx_param: serial line in, character holding register out.
interface uart_rx_if #(parameter int DW = 8);
  logic          rx;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  // valid/ready: a character transfers on every cycle with rx_valid && rx_ready; while
  // rx_valid is high and not accepted, rx_data and the error flags hold their values.
  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );
  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (data width, parity, stop bits) with valid/ready holding register.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around each nominal sample point.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.master  rx_if,
  output logic [2:0] o_dbg_state
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit_idx;
  logic                   r_stop_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_err;
  logic                   r_frm_err;
  logic                   r_wait_high;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_ovr;

  logic w_rx_s;
  logic w_bit;
  logic w_tick_mid;
  logic w_tick_last;
  logic w_done;
  logic w_done_ferr;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic r_rx_prev;
  logic w_rx_next;
  // The next-to-last synchroniser flop already holds rx_s one cycle early, so the
  // count-1/count/count+1 window is complete at the nominal count without extra delay.
  assign w_rx_next = r_sync[SYNC_STAGES-2];
  assign w_bit = (r_rx_prev & w_rx_s) | (r_rx_prev & w_rx_next) | (w_rx_s & w_rx_next);

  always_ff @(posedge clk) begin
    if (rst) r_rx_prev <= 1'b1;
    else     r_rx_prev <= w_rx_s;
  end
`else
  assign w_bit = w_rx_s;
`endif

  assign w_tick_mid  = (r_cnt == CNT_MID);
  assign w_tick_last = (r_cnt == CNT_LAST);
  assign w_done      = (r_state == S_STOP) && w_tick_last && ((STOP_BITS == 1) || r_stop_idx);
  assign w_done_ferr = r_frm_err | ~w_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync      <= '1;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_wait_high <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_if.rx};
      r_ovr  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // After a frame ending on a low stop sample (e.g. break), re-arm only once the line is high.
          if (r_wait_high) begin
            if (w_rx_s) r_wait_high <= 1'b0;
          end else if (!w_rx_s) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick_mid) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_state    <= w_bit ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_tick_last) begin
            r_cnt     <= '0;
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + BW'(1);
            if (r_bit_idx == BIT_LAST) r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_tick_last) begin
            r_cnt     <= '0;
            r_par_err <= ((^r_shift) ^ w_bit) != PAR_ODD;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_tick_last) begin
            r_cnt      <= '0;
            r_frm_err  <= w_done_ferr;
            r_stop_idx <= 1'b1;
            if (w_done) begin
              r_state     <= S_IDLE;
              r_wait_high <= ~w_bit;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_valid && rx_if.rx_ready) r_valid <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data  <= r_shift;
          r_perr  <= r_par_err;
          r_ferr  <= w_done_ferr;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.parity_err = r_perr;
  assign rx_if.frame_err  = r_ferr;
  assign rx_if.overrun    = r_ovr;
  assign rx_if.busy       = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and an 8E1 receiver at 16 clocks/bit, directed cases plus random frames.
module tb_uart_rx_param;
  localparam int CPB  = 16;
  localparam int SYNC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if #(.DW(8)) bus_n ();
  uart_rx_if #(.DW(8)) bus_e ();
  logic [2:0] dbg_n;
  logic [2:0] dbg_e;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC))
    u_dut_n (.clk(clk), .rst(rst), .rx_if(bus_n), .o_dbg_state(dbg_n));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(SYNC))
    u_dut_e (.clk(clk), .rst(rst), .rx_if(bus_e), .o_dbg_state(dbg_e));

  logic rx_line[2] = '{1'b1, 1'b1};
  logic rdy[2]     = '{1'b1, 1'b1};
  logic rand_rdy   = 1'b0;

  assign bus_n.rx       = rx_line[0];
  assign bus_e.rx       = rx_line[1];
  assign bus_n.rx_ready = rdy[0];
  assign bus_e.rx_ready = rdy[1];

  logic [7:0] m_data[2];
  logic m_valid[2], m_perr[2], m_ferr[2], m_ovr[2], m_busy[2];
  assign m_data[0]  = bus_n.rx_data;    assign m_data[1]  = bus_e.rx_data;
  assign m_valid[0] = bus_n.rx_valid;   assign m_valid[1] = bus_e.rx_valid;
  assign m_perr[0]  = bus_n.parity_err; assign m_perr[1]  = bus_e.parity_err;
  assign m_ferr[0]  = bus_n.frame_err;  assign m_ferr[1]  = bus_e.frame_err;
  assign m_ovr[0]   = bus_n.overrun;    assign m_ovr[1]   = bus_e.overrun;
  assign m_busy[0]  = bus_n.busy;       assign m_busy[1]  = bus_e.busy;

  // scoreboard state: entries are {frame_err, parity_err, data}
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  int vectors = 0;
  int miscompares = 0;
  logic       hold[2]       = '{1'b0, 1'b0};
  logic [9:0] held[2];
  logic       prev_valid[2] = '{1'b0, 1'b0};
  logic [9:0] last_acc[2]   = '{10'h0, 10'h0};
  int valid_cycles[2] = '{0, 0};
  int ovr_cycles[2]   = '{0, 0};
  int acc_count[2]    = '{0, 0};
  int rise_cyc[2]     = '{0, 0};
  int start_cyc[2]    = '{0, 0};
  logic [9:0] cur_m;
  logic [9:0] exp_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // compare process: every accepted character against the model, held characters for stability
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cur_m = {m_ferr[k], m_perr[k], m_data[k]};
      if (rst) begin
        hold[k]       = 1'b0;
        prev_valid[k] = 1'b0;
      end else begin
        if (m_valid[k]) valid_cycles[k]++;
        if (m_ovr[k]) ovr_cycles[k]++;
        if (m_valid[k] && !prev_valid[k]) rise_cyc[k] = cyc;
        if (hold[k]) check($sformatf("hold_stable%0d", k), 32'({m_valid[k], cur_m}), 32'({1'b1, held[k]}));
        if (m_valid[k] && rdy[k]) begin
          acc_count[k]++;
          last_acc[k] = cur_m;
          if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_char%0d: got 0x%0h, want no character", k, cur_m);
          end else begin
            exp_m = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("char%0d", k), 32'(cur_m), 32'(exp_m));
          end
        end
        hold[k]       = m_valid[k] && !rdy[k];
        held[k]       = cur_m;
        prev_valid[k] = m_valid[k];
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) for (int k = 0; k < 2; k++) rdy[k] = ($urandom_range(0, 3) != 0);
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input int k, input logic b);
    rx_line[k] = b;
    idle(CPB);
  endtask

  // Model: the character a frame must deliver, derived from the line contents.
  task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                            input logic stop_low, input bit push);
    logic pe;
    pe = (k == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
    if (push) begin
      if (k == 0) exp_q0.push_back({stop_low, pe, d});
      else        exp_q1.push_back({stop_low, pe, d});
    end
    start_cyc[k] = cyc;
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (k == 1) drive_bit(k, pbit);
    drive_bit(k, !stop_low);
    rx_line[k] = 1'b1;
  endtask

  task automatic rand_frame(input int k);
    logic [7:0] d;
    logic sl, pb;
    d  = 8'($urandom_range(0, 255));
    sl = ($urandom_range(0, 7) == 0);
    pb = 1'($urandom_range(0, 1));
    send_frame(k, d, pb, sl, 1);
    idle(sl ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 20)));
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 32'(m_valid[k]), 32'd0);
      check($sformatf("%s_data%0d", tag, k),  32'(m_data[k]),  32'd0);
      check($sformatf("%s_perr%0d", tag, k),  32'(m_perr[k]),  32'd0);
      check($sformatf("%s_ferr%0d", tag, k),  32'(m_ferr[k]),  32'd0);
      check($sformatf("%s_ovr%0d", tag, k),   32'(m_ovr[k]),   32'd0);
      check($sformatf("%s_busy%0d", tag, k),  32'(m_busy[k]),  32'd0);
    end
  endtask

  initial begin
    int vc, ov, ac, lat, exp_lat;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);

    // 8N1 0xA5, ready held high: one-cycle valid, clean character, latency from last stop mid-point
    vc = valid_cycles[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1);
    idle(20);
    check("a5_valid_cycles", 32'(valid_cycles[0] - vc), 32'd1);
    check("a5_literal", 32'(last_acc[0]), 32'h0A5);
    lat     = rise_cyc[0] - start_cyc[0];
    exp_lat = 9 * CPB + CPB / 2 + SYNC + 1;
    check("a5_latency_window", 32'((lat >= exp_lat) && (lat <= exp_lat + 1)), 32'd1);

    // 8E1 0x37: parity bit 0 is wrong (five ones), parity bit 1 is right
    send_frame(1, 8'h37, 1'b0, 1'b0, 1);
    idle(20);
    check("e37_bad_par_literal", 32'(last_acc[1]), 32'h137);
    send_frame(1, 8'h37, 1'b1, 1'b0, 1);
    idle(20);
    check("e37_good_par_literal", 32'(last_acc[1]), 32'h037);

    // stop bit low, then a clean frame
    send_frame(0, 8'h55, 1'b0, 1'b1, 1);
    idle(2 * CPB);
    check("55_frame_err_literal", 32'(last_acc[0]), 32'h255);
    send_frame(0, 8'h0F, 1'b0, 1'b0, 1);
    idle(20);
    check("0f_clean_literal", 32'(last_acc[0]), 32'h00F);

    // consumer stalled: 0x11 held, 0x22 dropped with a single overrun pulse
    rdy[0] = 1'b0;
    ov = ovr_cycles[0];
    send_frame(0, 8'h11, 1'b0, 1'b0, 1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 0);
    idle(20);
    check("ovr_pulse_cycles", 32'(ovr_cycles[0] - ov), 32'd1);
    check("ovr_held_data", 32'(m_data[0]), 32'h11);
    check("ovr_held_valid", 32'(m_valid[0]), 32'd1);
    rdy[0] = 1'b1;
    idle(5);
    check("ovr_drain_literal", 32'(last_acc[0]), 32'h011);
    check("ovr_valid_cleared", 32'(m_valid[0]), 32'd0);

    // 4-cycle glitch: start rejected, no character
    vc = valid_cycles[0];
    rx_line[0] = 1'b0;
    idle(4);
    rx_line[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_mid", 32'(m_busy[0]), 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_done", 32'(m_busy[0]), 32'd0);
    idle(30);
    check("glitch_no_valid", 32'(valid_cycles[0] - vc), 32'd0);

    // reset in the middle of the data bits of 0xFF, then 0x3C
    fork
      send_frame(0, 8'hFF, 1'b0, 1'b0, 0);
      begin
        idle(60);
        @(negedge clk);
        check("rst_mid_busy_before", 32'(m_busy[0]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        check_reset_state("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    idle(CPB);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1);
    idle(20);
    check("3c_after_reset_literal", 32'(last_acc[0]), 32'h03C);

    // break: one zero character with frame error, then no re-trigger while the line stays low
    ac = acc_count[0];
    send_frame(0, 8'h00, 1'b0, 1'b1, 1);
    rx_line[0] = 1'b0;
    idle(2 * CPB);
    rx_line[0] = 1'b1;
    idle(12 * CPB);
    check("break_literal", 32'(last_acc[0]), 32'h200);
    check("break_one_char", 32'(acc_count[0] - ac), 32'd1);

    // random frames on both receivers with random back-pressure
    rand_rdy = 1'b1;
    fork
      for (int i = 0; i < 25; i++) rand_frame(0);
      for (int j = 0; j < 25; j++) rand_frame(1);
    join
    idle(4);
    rand_rdy = 1'b0;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    idle(100);

    check("queue0_drained", 32'(exp_q0.size()), 32'd0);
    check("queue1_drained", 32'(exp_q1.size()), 32'd0);
    check("total_overruns", 32'(ovr_cycles[0] + ovr_cycles[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
